// File: rtl/decoder3_8_seq_if.sv
// decoder3_8_seq_if: code handshake in, registered one-hot strobe out.
interface decoder3_8_seq_if #(parameter int N = 3);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_code;
    logic           en;
    logic [2**N-1:0] y;
    logic           y_valid;
    logic           busy;
    modport master (output in_valid, in_code, en, input in_ready, y, y_valid, busy);
    modport slave  (input in_valid, in_code, en, output in_ready, y, y_valid, busy);
endinterface

// File: rtl/decoder3_8_seq.sv
// decoder3_8_seq: queued binary codes emitted as HOLD-cycle one-hot pulses spaced by GAP zero cycles.
module decoder3_8_seq #(
    parameter int N     = 3,
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    decoder3_8_seq_if.slave bus
);
    localparam int W  = 2**N;
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD) + 1;
    localparam int GW = $clog2(GAP + 1) + 1;
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;
    state_t        state, state_n;
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [W-1:0]  y, y_n;
    logic          y_valid, push, can_pop, load;
    assign bus.in_ready = count != (AW+1)'(DEPTH);
    assign push         = bus.in_valid & bus.in_ready;
    assign can_pop      = (count != '0) & bus.en;
    assign bus.y        = y;
    assign bus.y_valid  = y_valid;
    assign bus.busy     = (state != S_IDLE) | (count != '0);
    always_comb begin
        state_n = state;
        y_n     = y;
        hcnt_n  = hcnt;
        gcnt_n  = gcnt;
        load    = 1'b0;
        case (state)
            S_IDLE: load = can_pop;
            S_DRIVE: begin
                if (hcnt != '0) begin
                    hcnt_n = hcnt - 1'b1;
                end else if (GAP > 0) begin
                    y_n     = '0;
                    gcnt_n  = GW'(GAP - 1);
                    state_n = S_GAP;
                end else if (can_pop) begin
                    load = 1'b1;
                end else begin
                    y_n     = '0;
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (gcnt != '0) gcnt_n = gcnt - 1'b1;
                else if (can_pop) load = 1'b1;
                else state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // A load overrides whatever the current state decided.
        if (load) begin
            y_n     = W'(1) << mem[rp];
            hcnt_n  = HW'(HOLD - 1);
            state_n = S_DRIVE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            y       <= '0;
            y_valid <= 1'b0;
            hcnt    <= '0;
            gcnt    <= '0;
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
        end else begin
            state   <= state_n;
            y       <= y_n;
            y_valid <= y_n != '0;
            hcnt    <= hcnt_n;
            gcnt    <= gcnt_n;
            wp      <= wp + AW'(push);
            rp      <= rp + AW'(load);
            count   <= count + (AW+1)'(push) - (AW+1)'(load);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= bus.in_code;
    end
endmodule

// File: tb/tb_decoder3_8_seq.sv
// tb_decoder3_8_seq: vector table, directed corner sequences and random traffic against a timing model.
module tb_decoder3_8_seq;
    localparam int HOLD  = 4;
    localparam int GAP   = 1;
    localparam int DEPTH = 4;
    typedef struct {
        logic       rst, valid, en;
        logic [2:0] code;
        logic [7:0] y;
        logic       busy, ready;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   mq[$];
    int   seen[$];
    int   m_k = 0, m_start = -1000, m_next = 0, m_code = 0;
    logic [7:0] prev_y = '0;
    vec_t vt[24];
    decoder3_8_seq_if #(.N(3)) bus ();
    decoder3_8_seq #(.N(3), .HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask
    function automatic int code_of(logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction
    // Model: a pulse may start at any edge at or after the previous pulse's start + HOLD + GAP.
    task automatic step();
        bit do_push, do_load;
        logic [7:0] ey;
        m_k++;
        if (rst) begin
            mq.delete();
            m_start = -1000;
            m_next  = m_k;
        end else begin
            do_push = bus.in_valid && (mq.size() != DEPTH);
            do_load = (mq.size() != 0) && bus.en && (m_k >= m_next);
            if (do_load) begin
                m_code  = mq.pop_front();
                m_start = m_k;
                m_next  = m_k + HOLD + GAP;
            end
            if (do_push) mq.push_back(int'(bus.in_code));
        end
        @(posedge clk);
        #1;
        ey = (m_k >= m_start && m_k - m_start < HOLD) ? (8'd1 << m_code) : 8'd0;
        check("model_y", bus.y, ey);
        check("model_y_valid", bus.y_valid, ey != 0);
        check("model_busy", bus.busy, (m_k < m_next) || (mq.size() != 0));
        check("model_in_ready", bus.in_ready, mq.size() != DEPTH);
        if (bus.y != 0 && prev_y == 0) seen.push_back(code_of(bus.y));
        prev_y = bus.y;
    endtask
    task automatic drive(logic r, logic v, logic e, logic [2:0] c);
        rst = r;
        bus.in_valid = v;
        bus.en = e;
        bus.in_code = c;
    endtask
    task automatic do_reset();
        drive(1, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        seen.delete();
    endtask
    initial begin
        int nxt;
        bit saw_full, acc;
        int exp6[5];
        drive(1, 0, 0, 0);
        vt = '{
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b1, 3'd5, 8'h00, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h20, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h20, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h20, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h20, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 3'd6, 8'h00, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h04, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h04, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h04, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h04, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h40, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h40, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h40, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h40, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1}
        };
        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].valid, vt[i].en, vt[i].code);
            step();
            check($sformatf("vec%0d_y", i), bus.y, vt[i].y);
            check($sformatf("vec%0d_y_valid", i), bus.y_valid, vt[i].y != 0);
            check($sformatf("vec%0d_busy", i), bus.busy, vt[i].busy);
            check($sformatf("vec%0d_in_ready", i), bus.in_ready, vt[i].ready);
        end
        // Streaming 0..7 with continuous push attempts.
        do_reset();
        nxt = 0;
        saw_full = 0;
        for (int c = 0; c < 120; c++) begin
            drive(0, nxt < 8, 1, 3'(nxt));
            if (!bus.in_ready) saw_full = 1;
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) nxt++;
        end
        check("stream_pushed", nxt, 8);
        check("stream_full_seen", saw_full, 1);
        check("stream_pulses", seen.size(), 8);
        foreach (seen[i]) check($sformatf("stream_order%0d", i), seen[i], i);
        // Reset in the second DRIVE cycle discards the queue.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 0, 3'(i));
            step();
        end
        drive(0, 0, 1, 0);
        step();
        step();
        check("rst_mid_pre_y", bus.y, 8'h02);
        rst = 1'b1;
        step();
        check("rst_mid_y", bus.y, 8'h00);
        check("rst_mid_busy", bus.busy, 1'b0);
        rst = 1'b0;
        seen.delete();
        for (int i = 0; i < 20; i++) step();
        check("rst_mid_no_pulses", seen.size(), 0);
        // Full queue: a push at a pop edge is refused, then accepted next edge.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 0, 3'(i));
            step();
        end
        check("full_ready_low", bus.in_ready, 1'b0);
        drive(0, 1, 1, 3'd7);
        step();
        check("full_pop_y", bus.y, 8'h02);
        check("full_ready_after_pop", bus.in_ready, 1'b1);
        step();
        check("full_accept_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) step();
        exp6 = '{1, 2, 3, 4, 7};
        check("full_pulses", seen.size(), 5);
        foreach (seen[i]) if (i < 5) check($sformatf("full_order%0d", i), seen[i], exp6[i]);
        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
